// File: rtl/aes_mmio_pkg.sv
// Shared address map, register bit positions and controller state encoding
// for the AES memory-mapped responder.
package aes_mmio_pkg;

    localparam int ADDR_CTRL    = 'h08;
    localparam int ADDR_STATUS  = 'h09;
    localparam int ADDR_CONFIG  = 'h0A;
    localparam int ADDR_KEY0    = 'h10;
    localparam int ADDR_BLOCK0  = 'h20;
    localparam int ADDR_RESULT0 = 'h30;

    localparam int BLOCK_WORDS = 4;
    localparam int BLOCK_W     = 128;

    localparam int CTRL_INIT_BIT     = 0;
    localparam int CTRL_NEXT_BIT     = 1;
    localparam int STATUS_READY_BIT  = 0;
    localparam int STATUS_VALID_BIT  = 1;
    localparam int STATUS_BUSY_BIT   = 2;
    localparam int CONFIG_ENCDEC_BIT = 0;
    localparam int CONFIG_KEYLEN_BIT = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INIT_WAIT = 2'd1,
        NEXT_WAIT = 2'd2,
        CAPTURE   = 2'd3
    } aes_mmio_state_e;

endpackage

// File: rtl/aes_mmio_ctrl_fsm.sv
// Command sequencer: issues init/next pulses to the AES core, waits for the
// core to finish and owns the result-valid flag.
module aes_mmio_ctrl_fsm
    import aes_mmio_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cmd_init,
    input  logic            i_cmd_next,
    input  logic            i_block_wr,
    input  logic            i_core_ready,
    input  logic            i_core_valid,
    output aes_mmio_state_e o_state,
    output logic            o_init,
    output logic            o_next,
    output logic            o_valid,
    output logic            o_capture
);

    aes_mmio_state_e r_state;
    aes_mmio_state_e w_state_next;
    logic [1:0]      r_wait_cnt;
    logic            r_init;
    logic            r_next;
    logic            r_valid;
    logic            w_wait_done;

    // The core's ready/valid may still reflect the previous operation right
    // after a pulse, so they are ignored for the first two cycles.
    assign w_wait_done = (r_wait_cnt == 2'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE || r_state == CAPTURE) begin
                r_wait_cnt <= 2'd0;
            end else if (!w_wait_done) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_cmd_init) begin
                    w_state_next = INIT_WAIT;
                end else if (i_cmd_next) begin
                    w_state_next = NEXT_WAIT;
                end
            end
            INIT_WAIT: if (w_wait_done && i_core_ready) w_state_next = IDLE;
            NEXT_WAIT: if (w_wait_done && i_core_valid) w_state_next = CAPTURE;
            CAPTURE:   w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init  <= 1'b0;
            r_next  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_init <= i_cmd_init;
            r_next <= i_cmd_next;
            if (r_state == CAPTURE) begin
                r_valid <= 1'b1;
            end else if (i_cmd_next || i_block_wr) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        o_state   = r_state;
        o_init    = r_init;
        o_next    = r_next;
        o_valid   = r_valid;
        o_capture = (r_state == CAPTURE);
    end

endmodule

// File: rtl/aes_mmio_slave.sv
// Bus-facing register file for the AES core: address decode, operand and
// result registers, and a registered single-cycle acknowledge path.
module aes_mmio_slave
    import aes_mmio_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int KEY_WORDS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic                        ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        err_o,
    output logic                        core_init_o,
    output logic                        core_next_o,
    output logic                        core_encdec_o,
    output logic                        core_keylen_o,
    output logic [DATA_W*KEY_WORDS-1:0] core_key_o,
    output logic [BLOCK_W-1:0]          core_block_o,
    input  logic                        core_ready_i,
    input  logic [BLOCK_W-1:0]          core_result_i,
    input  logic                        core_valid_i
);

    localparam int KIDX_W = $clog2(KEY_WORDS);

    logic [DATA_W-1:0] r_key    [KEY_WORDS];
    logic [DATA_W-1:0] r_block  [BLOCK_WORDS];
    logic [DATA_W-1:0] r_result [BLOCK_WORDS];
    logic [1:0]        r_config;
    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    aes_mmio_state_e   w_state;
    logic [31:0]       w_addr;
    logic              w_hit_ctrl, w_hit_status, w_hit_config;
    logic              w_hit_key, w_hit_block, w_hit_result, w_mapped;
    logic              w_busy, w_err, w_wr_ok, w_ctrl_wr;
    logic              w_init, w_next, w_valid, w_capture;
    logic [DATA_W-1:0] w_rdata;

    assign w_addr       = 32'(addr_i);
    assign w_hit_ctrl   = (w_addr == 32'(ADDR_CTRL));
    assign w_hit_status = (w_addr == 32'(ADDR_STATUS));
    assign w_hit_config = (w_addr == 32'(ADDR_CONFIG));
    assign w_hit_key    = (w_addr >= 32'(ADDR_KEY0))
                       && (w_addr < 32'(ADDR_KEY0 + KEY_WORDS));
    assign w_hit_block  = (w_addr >= 32'(ADDR_BLOCK0))
                       && (w_addr < 32'(ADDR_BLOCK0 + BLOCK_WORDS));
    assign w_hit_result = (w_addr >= 32'(ADDR_RESULT0))
                       && (w_addr < 32'(ADDR_RESULT0 + BLOCK_WORDS));
    assign w_mapped     = w_hit_ctrl | w_hit_status | w_hit_config
                        | w_hit_key | w_hit_block | w_hit_result;

    assign w_busy = (w_state != IDLE);

    // Operand and command writes are refused while busy so the core sees
    // stable inputs for the whole operation.
    assign w_err = !w_mapped
                 || (we_i && (w_hit_status || w_hit_result))
                 || (!we_i && w_hit_key)
                 || (we_i && w_busy && (w_hit_ctrl || w_hit_key
                                        || w_hit_block || w_hit_config));

    assign w_wr_ok   = req_i && we_i && !w_err;
    assign w_ctrl_wr = w_wr_ok && w_hit_ctrl;

    aes_mmio_ctrl_fsm u_fsm (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_cmd_init   (w_ctrl_wr && wdata_i[CTRL_INIT_BIT]),
        .i_cmd_next   (w_ctrl_wr && !wdata_i[CTRL_INIT_BIT] && wdata_i[CTRL_NEXT_BIT]),
        .i_block_wr   (w_wr_ok && w_hit_block),
        .i_core_ready (core_ready_i),
        .i_core_valid (core_valid_i),
        .o_state      (w_state),
        .o_init       (w_init),
        .o_next       (w_next),
        .o_valid      (w_valid),
        .o_capture    (w_capture)
    );

    always_comb begin
        w_rdata = '0;
        if (!we_i && !w_err) begin
            if (w_hit_status) begin
                w_rdata[STATUS_READY_BIT] = core_ready_i;
                w_rdata[STATUS_VALID_BIT] = w_valid;
                w_rdata[STATUS_BUSY_BIT]  = w_busy;
            end else if (w_hit_config) begin
                w_rdata[1:0] = r_config;
            end else if (w_hit_block) begin
                w_rdata = r_block[addr_i[1:0]];
            end else if (w_hit_result) begin
                w_rdata = r_result[addr_i[1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= req_i;
            r_err   <= req_i && w_err;
            r_rdata <= req_i ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_config <= 2'b00;
            for (int i = 0; i < KEY_WORDS; i++) r_key[i] <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_block[i]  <= '0;
                r_result[i] <= '0;
            end
        end else begin
            if (w_wr_ok && w_hit_config) r_config <= wdata_i[1:0];
            if (w_wr_ok && w_hit_key)    r_key[addr_i[KIDX_W-1:0]] <= wdata_i;
            if (w_wr_ok && w_hit_block)  r_block[addr_i[1:0]] <= wdata_i;
            if (w_capture) begin
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    r_result[i] <= core_result_i[BLOCK_W-1-32*i -: 32];
                end
            end
        end
    end

    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
        assign core_key_o[DATA_W*(KEY_WORDS-g)-1 -: DATA_W] = r_key[g];
    end
    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_block
        assign core_block_o[BLOCK_W-1-32*g -: 32] = r_block[g];
    end

    assign ack_o         = r_ack;
    assign err_o         = r_err;
    assign rdata_o       = r_rdata;
    assign core_init_o   = w_init;
    assign core_next_o   = w_next;
    assign core_encdec_o = r_config[CONFIG_ENCDEC_BIT];
    assign core_keylen_o = r_config[CONFIG_KEYLEN_BIT];

endmodule

// File: tb/tb_aes_mmio_slave.sv
// Bench for aes_mmio_slave: table of register accesses plus hand-written
// command sequences, with bus responses checked against an expected queue.
module tb_aes_mmio_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_i, we_i;
    logic [7:0]   addr_i;
    logic [31:0]  wdata_i;
    logic         ack_o, err_o;
    logic [31:0]  rdata_o;
    logic         core_init_o, core_next_o, core_encdec_o, core_keylen_o;
    logic [255:0] core_key_o;
    logic [127:0] core_block_o;
    logic         core_ready_i, core_valid_i;
    logic [127:0] core_result_i;

    always #5 clk = ~clk;

    aes_mmio_slave dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .ack_o         (ack_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .core_init_o   (core_init_o),
        .core_next_o   (core_next_o),
        .core_encdec_o (core_encdec_o),
        .core_keylen_o (core_keylen_o),
        .core_key_o    (core_key_o),
        .core_block_o  (core_block_o),
        .core_ready_i  (core_ready_i),
        .core_result_i (core_result_i),
        .core_valid_i  (core_valid_i)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [24];
    logic [40:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          init_cnt = 0;
    int          next_cnt = 0;
    logic        req_seen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_seen <= 1'b0;
        else        req_seen <= req_i;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and check whatever the bus returned.
    task automatic tick();
        logic [40:0] e;
        @(negedge clk);
        if (core_init_o) init_cnt++;
        if (core_next_o) next_cnt++;
        if (rst_n) begin
            if (req_seen || ack_o) chk("ack_timing", 256'(ack_o), 256'(req_seen));
            if (ack_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack with empty queue, expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rdata@%02h", e[40:33]), 256'(rdata_o), 256'(e[31:0]));
                    chk($sformatf("err@%02h", e[40:33]), 256'(err_o), 256'(e[32]));
                end
            end else begin
                chk("idle_rdata", 256'(rdata_o), 256'(0));
                chk("idle_err", 256'(err_o), 256'(0));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic we, input logic [7:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rd, input logic exp_e);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = data;
        exp_q.push_back({addr, exp_e, exp_rd});
    endtask

    task automatic idle_bus();
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 8'h00;
        wdata_i = 32'h0;
    endtask

    // Returns in the ack cycle of the access.
    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic exp_e);
        drive(we, addr, data, exp_rd, exp_e);
        tick();
        idle_bus();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h10, 32'h2b7e1516, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 32'h28aed2a6, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 8'h12, 32'habf71588, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 8'h13, 32'h09cf4f3c, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 8'h0A, 32'h00000001, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 8'h0A, 32'h0, 32'h00000001, 1'b0};
        tbl[6]  = '{1'b0, 8'h10, 32'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 8'h30, 32'h11111111, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, 8'h7F, 32'h0, 32'h0, 1'b1};
        tbl[9]  = '{1'b1, 8'h7F, 32'hdeadbeef, 32'h0, 1'b1};
        tbl[10] = '{1'b1, 8'h09, 32'hffffffff, 32'h0, 1'b1};
        tbl[11] = '{1'b0, 8'h30, 32'h0, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 8'h08, 32'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b1, 8'h20, 32'h6bc1bee2, 32'h0, 1'b0};
        tbl[14] = '{1'b1, 8'h21, 32'h2e409f96, 32'h0, 1'b0};
        tbl[15] = '{1'b1, 8'h22, 32'he93d7e11, 32'h0, 1'b0};
        tbl[16] = '{1'b1, 8'h23, 32'h7393172a, 32'h0, 1'b0};
        tbl[17] = '{1'b0, 8'h22, 32'h0, 32'he93d7e11, 1'b0};
        tbl[18] = '{1'b0, 8'h09, 32'h0, 32'h0, 1'b0};
        tbl[19] = '{1'b1, 8'h0A, 32'hfffffffd, 32'h0, 1'b0};
        tbl[20] = '{1'b0, 8'h0A, 32'h0, 32'h00000001, 1'b0};
        tbl[21] = '{1'b1, 8'h18, 32'h12345678, 32'h0, 1'b1};
        tbl[22] = '{1'b0, 8'h24, 32'h0, 32'h0, 1'b1};
        tbl[23] = '{1'b0, 8'h33, 32'h0, 32'h0, 1'b0};

        idle_bus();
        rst_n         = 1'b0;
        core_ready_i  = 1'b0;
        core_valid_i  = 1'b0;
        core_result_i = '0;

        // Reset
        ticks(3);
        chk("rst_ack", 256'(ack_o), 256'(0));
        chk("rst_init", 256'(core_init_o), 256'(0));
        chk("rst_next", 256'(core_next_o), 256'(0));
        chk("rst_key", core_key_o, 256'(0));
        chk("rst_block", 256'(core_block_o), 256'(0));
        chk("rst_cfg", 256'({core_encdec_o, core_keylen_o}), 256'(0));
        rst_n = 1'b1;
        tick();
        bus(1'b0, 8'h09, 32'h0, 32'h0, 1'b0);

        // Register map table
        for (int i = 0; i < 24; i++) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
            tick();
        end
        chk("key_hi", 256'(core_key_o[255:128]),
            256'({32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c}));
        chk("key_lo", 256'(core_key_o[127:0]), 256'(0));
        chk("block", 256'(core_block_o),
            256'({32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a}));
        chk("encdec", 256'(core_encdec_o), 256'(1));
        chk("keylen", 256'(core_keylen_o), 256'(0));

        // Back-to-back reads of BLOCK0..3
        drive(1'b0, 8'h20, 32'h0, 32'h6bc1bee2, 1'b0); tick();
        drive(1'b0, 8'h21, 32'h0, 32'h2e409f96, 1'b0); tick();
        drive(1'b0, 8'h22, 32'h0, 32'he93d7e11, 1'b0); tick();
        drive(1'b0, 8'h23, 32'h0, 32'h7393172a, 1'b0); tick();
        idle_bus();
        tick();

        // Key init while the core reports not ready
        bus(1'b1, 8'h08, 32'h1, 32'h0, 1'b0);
        chk("init_pulse", 256'(core_init_o), 256'(1));
        chk("init_no_next", 256'(core_next_o), 256'(0));
        drive(1'b0, 8'h09, 32'h0, 32'h4, 1'b0);
        tick();
        idle_bus();
        chk("init_one_cycle", 256'(core_init_o), 256'(0));
        ticks(4);
        core_ready_i = 1'b1;
        ticks(4);
        bus(1'b0, 8'h09, 32'h0, 32'h1, 1'b0);
        tick();

        // init+next together: init wins; core ready throughout
        bus(1'b1, 8'h08, 32'h3, 32'h0, 1'b0);
        chk("both_init", 256'(core_init_o), 256'(1));
        chk("both_no_next", 256'(core_next_o), 256'(0));
        drive(1'b0, 8'h09, 32'h0, 32'h5, 1'b0); tick();
        drive(1'b0, 8'h09, 32'h0, 32'h5, 1'b0); tick();
        idle_bus();
        ticks(3);
        bus(1'b0, 8'h09, 32'h0, 32'h1, 1'b0);
        tick();
        chk("init_count", 256'(init_cnt), 256'(2));
        chk("next_count0", 256'(next_cnt), 256'(0));

        // Encrypt, with a RESULT read landing in the capture cycle
        bus(1'b1, 8'h08, 32'h2, 32'h0, 1'b0);
        chk("next_pulse", 256'(core_next_o), 256'(1));
        core_ready_i = 1'b0;
        bus(1'b0, 8'h09, 32'h0, 32'h4, 1'b0);
        ticks(8);
        core_result_i = 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97;
        core_valid_i  = 1'b1;
        tick();
        drive(1'b0, 8'h30, 32'h0, 32'h0, 1'b0); tick();
        drive(1'b0, 8'h30, 32'h0, 32'h3ad77bb4, 1'b0); tick();
        idle_bus();
        core_valid_i = 1'b0;
        core_ready_i = 1'b1;
        drive(1'b0, 8'h31, 32'h0, 32'h0d7a3660, 1'b0); tick();
        drive(1'b0, 8'h32, 32'h0, 32'ha89ecaf3, 1'b0); tick();
        drive(1'b0, 8'h33, 32'h0, 32'h2466ef97, 1'b0); tick();
        drive(1'b0, 8'h09, 32'h0, 32'h3, 1'b0); tick();
        idle_bus();
        tick();

        // Busy protection
        bus(1'b1, 8'h08, 32'h2, 32'h0, 1'b0);
        core_ready_i = 1'b0;
        bus(1'b1, 8'h20, 32'hdeadbeef, 32'h0, 1'b1);
        bus(1'b1, 8'h08, 32'h1, 32'h0, 1'b1);
        bus(1'b1, 8'h14, 32'hcafef00d, 32'h0, 1'b1);
        bus(1'b1, 8'h0A, 32'h2, 32'h0, 1'b1);
        bus(1'b0, 8'h09, 32'h0, 32'h4, 1'b0);
        bus(1'b0, 8'h20, 32'h0, 32'h6bc1bee2, 1'b0);
        chk("busy_init_count", 256'(init_cnt), 256'(2));
        chk("busy_next_count", 256'(next_cnt), 256'(2));
        core_result_i = 128'h01234567_89abcdef_fedcba98_76543210;
        core_valid_i  = 1'b1;
        ticks(3);
        core_valid_i = 1'b0;
        core_ready_i = 1'b1;
        bus(1'b0, 8'h30, 32'h0, 32'h01234567, 1'b0);
        bus(1'b0, 8'h33, 32'h0, 32'h76543210, 1'b0);
        bus(1'b0, 8'h09, 32'h0, 32'h3, 1'b0);
        bus(1'b0, 8'h0A, 32'h0, 32'h1, 1'b0);
        chk("busy_key_kept", 256'(core_key_o[127:96]), 256'(0));
        chk("busy_block_kept", 256'(core_block_o[127:96]), 256'(32'h6bc1bee2));
        bus(1'b1, 8'h23, 32'h7393172a, 32'h0, 1'b0);
        bus(1'b0, 8'h09, 32'h0, 32'h1, 1'b0);
        tick();

        // Reset during NEXT_WAIT
        core_ready_i = 1'b0;
        bus(1'b1, 8'h08, 32'h2, 32'h0, 1'b0);
        ticks(3);
        rst_n = 1'b0;
        core_valid_i = 1'b1;
        #1;
        chk("midrst_next", 256'(core_next_o), 256'(0));
        chk("midrst_key", core_key_o, 256'(0));
        chk("midrst_block", 256'(core_block_o), 256'(0));
        chk("midrst_cfg", 256'({core_encdec_o, core_keylen_o}), 256'(0));
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        chk("midrst_init_count", 256'(init_cnt), 256'(2));
        chk("midrst_next_count", 256'(next_cnt), 256'(3));
        core_valid_i = 1'b0;
        bus(1'b0, 8'h09, 32'h0, 32'h0, 1'b0);
        bus(1'b0, 8'h30, 32'h0, 32'h0, 1'b0);
        bus(1'b0, 8'h0A, 32'h0, 32'h0, 1'b0);
        bus(1'b0, 8'h20, 32'h0, 32'h0, 1'b0);
        ticks(2);
        chk("queue_drained", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_mmio_slave.md
Name: aes_mmio_slave

Overview:
- Memory-mapped responder for the AES peripheral. It sits between the CPU load/store path and the AES core.
- Decodes word addresses for the BLOCK, KEY, CTRL, CONFIG, STATUS and RESULT registers. These are the same addresses the CPU immediate path produces.
- Holds operand registers, sequences the init/next command handshake to the core, and captures results for CPU readback.

Parameters:
- ADDR_W, 8, word-address width of the peripheral window.
- DATA_W, 32, bus data width (fixed at 32; other values are not supported).
- KEY_WORDS, 8, number of key registers (supports 256-bit keys).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  bus request, valid for one cycle per transaction
- we_i  in  1  1=write, 0=read
- addr_i  in  ADDR_W  word address
- wdata_i  in  32  write data
- ack_o  out  1  transaction acknowledge
- rdata_o  out  32  read data, valid when ack_o=1
- err_o  out  1  unmapped address or illegal access, valid with ack_o
- core_init_o  out  1  one-cycle key-expansion start pulse
- core_next_o  out  1  one-cycle block-processing start pulse
- core_encdec_o  out  1  1=encrypt, 0=decrypt (CONFIG[0])
- core_keylen_o  out  1  0=128-bit key, 1=256-bit key (CONFIG[1])
- core_key_o  out  32*KEY_WORDS  concatenated KEY registers, KEY0 in the MSBs
- core_block_o  out  128  concatenated BLOCK0..3, BLOCK0 in the MSBs
- core_ready_i  in  1  core idle/ready
- core_result_i  in  128  core output block
- core_valid_i  in  1  result valid (level)

Behaviour:
- Address map (word offsets):
  - CTRL 0x08: W, bit0 init, bit1 next; reads return 0.
  - STATUS 0x09: R, bit0 ready, bit1 valid, bit2 busy.
  - CONFIG 0x0A: R/W, bits[1:0].
  - KEY0..7 0x10-0x17: W.
  - BLOCK0..3 0x20-0x23: R/W.
  - RESULT0..3 0x30-0x33: R.
- Bus handshake: ack_o asserts exactly 1 cycle after req_i (registered). rdata_o and err_o are valid in that same cycle; otherwise rdata_o=0 and err_o=0. Back-to-back requests on consecutive cycles are each acked.
- err_o=1 for:
  - any unmapped address;
  - a write to STATUS or RESULT;
  - a read of KEY.
  Erroneous accesses change no state and return rdata_o=0.
- Reset values: every register, all outputs and the FSM are 0 / IDLE.
- FSM states:
  - IDLE, on a CTRL write:
    - bit0=1 -> pulse core_init_o, go to INIT_WAIT.
    - else bit1=1 -> pulse core_next_o, go to NEXT_WAIT.
    - both bits set -> init only (init has priority).
  - INIT_WAIT -> IDLE on the first cycle with core_ready_i=1, no earlier than 2 cycles after the pulse.
  - NEXT_WAIT -> CAPTURE when core_valid_i=1, no earlier than 2 cycles after the pulse.
  - CAPTURE: core_result_i is latched into RESULT0..3 and the valid flag is set; -> IDLE next cycle.
- Command pulses are registered: asserted in the ack cycle of the CTRL write, high for exactly one cycle.
- Busy: STATUS.busy=1 whenever the state is not IDLE. While busy:
  - CTRL writes are acked with err_o=1 and ignored.
  - KEY, BLOCK and CONFIG writes are acked with err_o=1 and ignored, so operands stay stable.
- Valid flag: cleared by a next command, and cleared by any BLOCK write; set only in CAPTURE.
- STATUS.ready mirrors core_ready_i, sampled in the ack cycle.
- Simultaneous events: a bus read of RESULT during the CAPTURE cycle returns the old value. The new value is visible from the following request.
- Reset mid-operation: everything returns immediately to reset values; no pulse may be emitted during or after reset release.

Decomposition:
- Package aes_mmio_pkg holds:
  - address localparams ADDR_CTRL, ADDR_STATUS, ADDR_CONFIG, ADDR_KEY0, ADDR_BLOCK0, ADDR_RESULT0;
  - CTRL/STATUS bit-index constants;
  - state enum aes_mmio_state_e {IDLE, INIT_WAIT, NEXT_WAIT, CAPTURE}.
- One sub-module, aes_mmio_ctrl_fsm: owns the state register, the command pulses and the valid flag. The top owns address decode, the register file and the read mux.

Test Plan:
- Reset: hold rst_ni=0, then release -> all outputs 0, STATUS read = 0x0 (with core_ready_i=0), ack_o exactly 1 cycle after req_i.
- Load and init: write KEY0..3=0x2b7e1516,0x28aed2a6,0xabf71588,0x09cf4f3c; write CONFIG=0x1; write CTRL=0x1 -> core_init_o high for one cycle, core_key_o[255:128] matches the written words, STATUS.busy=1 until core_ready_i is raised.
- Encrypt: write BLOCK0..3=0x6bc1bee2,0x2e409f96,0xe93d7e11,0x7393172a; write CTRL=0x2; model core_valid_i after 10 cycles with result 0x3ad77bb4_0d7a3660_a89ecaf3_2466ef97 -> RESULT0 reads 0x3ad77bb4, STATUS=0x3.
- Busy protection: write CTRL=0x2, then write BLOCK0=0xdeadbeef while busy -> err_o=1, BLOCK0 unchanged, no second core_next_o pulse.
- Errors: read 0x10, write 0x30, access 0x7f -> err_o=1, rdata_o=0, no state change.
- Reset mid-op: assert rst_ni=0 during NEXT_WAIT -> state returns to IDLE, valid=0, RESULT=0, no pulse after release.
